cacheline_adapter: RTL

- Sits directly downstream of the cache controller/datapath, on the RAM side.
- Converts the cache's single-transfer line interface into the physical memory's fixed-length burst interface: read_i/write_i/resp_o/line on one side, read_o/write_o/resp_i/64-bit beats on the other.
- Buffers one full line in each direction.
- Handles one outstanding transaction at a time.

---
 rtl/cacheline_adapter.sv | 115 +++++++++++
 1 files changed

// File: rtl/cacheline_adapter.sv
// Cache-line to memory-burst adapter: turns single-transfer line reads/writes into
// fixed-length beat bursts, buffering one full line in each direction.
module cacheline_adapter #(
   parameter int unsigned s_line   = 256,
   parameter int unsigned s_burst  = 64,
   parameter int unsigned s_offset = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   input  logic [s_line-1:0]  line_i,
   output logic [s_line-1:0]  line_o,
   output logic               resp_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   output logic [s_burst-1:0] burst_o,
   input  logic [s_burst-1:0] burst_i,
   input  logic               resp_i
);

   localparam int unsigned burst_len = s_line / s_burst;
   localparam int unsigned CntW      = (burst_len > 1) ? $clog2(burst_len) : 1;
   localparam logic [CntW-1:0] LastBeat = CntW'(burst_len - 1);
   localparam logic [31:0] AddrMask  = ~((32'd1 << s_offset) - 32'd1);

   localparam logic [2:0] StIdle      = 3'd0;
   localparam logic [2:0] StRead      = 3'd1;
   localparam logic [2:0] StReadDone  = 3'd2;
   localparam logic [2:0] StWrite     = 3'd3;
   localparam logic [2:0] StWriteDone = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [s_line-1:0] wbuf_q, wbuf_d;
   logic [s_line-1:0] rbuf_q, rbuf_d;
   logic [s_line-1:0] line_q, line_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wbuf_d  = wbuf_q;
      rbuf_d  = rbuf_q;
      line_d  = line_q;
      case (state_q)
         StIdle: begin
            // Writeback wins so a dirty victim leaves before its replacement is fetched.
            if (write_i) begin
               wbuf_d  = line_i;
               addr_d  = address_i & AddrMask;
               cnt_d   = '0;
               state_d = StWrite;
            end else if (read_i) begin
               addr_d  = address_i & AddrMask;
               cnt_d   = '0;
               state_d = StRead;
            end
         end
         StRead: begin
            if (resp_i) begin
               rbuf_d[cnt_q*s_burst +: s_burst] = burst_i;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastBeat) begin
                  // line_o only moves when a fill completes, so it holds across writes.
                  line_d  = rbuf_d;
                  state_d = StReadDone;
               end
            end
         end
         StWrite: begin
            if (resp_i) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastBeat) begin
                  state_d = StWriteDone;
               end
            end
         end
         StReadDone:  state_d = StIdle;
         StWriteDone: state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         wbuf_q  <= '0;
         rbuf_q  <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wbuf_q  <= wbuf_d;
         rbuf_q  <= rbuf_d;
         line_q  <= line_d;
      end
   end

   always_comb begin
      read_o    = (state_q == StRead);
      write_o   = (state_q == StWrite);
      resp_o    = (state_q == StReadDone) || (state_q == StWriteDone);
      address_o = (read_o || write_o) ? addr_q : '0;
      burst_o   = write_o ? wbuf_q[cnt_q*s_burst +: s_burst] : '0;
      line_o    = line_q;
   end

endmodule
